// File: rtl/vote_pkg.sv
// Shared types and defaults for the vote_tally block.
// The optional VOTE_TIE_DETECT_EN build is handled in vote_max_scan and vote_tally.
package vote_pkg;

  localparam int DEF_NUM_CAND = 4;
  localparam int DEF_CNT_W    = 8;

  typedef enum logic [1:0] {
    VOTE   = 2'd0,
    SCAN   = 2'd1,
    RESULT = 2'd2
  } vote_state_e;

  // Index width that stays legal even for a single-entry range.
  function automatic int idx_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vote_tally_if.sv
// Ballot inputs and tally/result outputs of vote_tally, grouped as one bundle.
// master drives the ballot side, slave is the tally block.
interface vote_tally_if import vote_pkg::*; #(
  parameter int NUM_CAND = DEF_NUM_CAND,
  parameter int CNT_W    = DEF_CNT_W
);

  logic                                mode;
  logic [NUM_CAND-1:0]                 cand_valid_vote;
  logic [NUM_CAND*CNT_W-1:0]           cand_vote_recvd;
  logic [CNT_W+$clog2(NUM_CAND)-1:0]   total_votes;
  logic                                vote_accept;
  logic                                vote_reject;
  logic                                overflow;
  logic [idx_w(NUM_CAND)-1:0]          winner_idx;
  logic                                winner_valid;
  logic                                tie;

  modport master (
    output mode, cand_valid_vote,
    input  cand_vote_recvd, total_votes, vote_accept, vote_reject,
           overflow, winner_idx, winner_valid, tie
  );

  modport slave (
    input  mode, cand_valid_vote,
    output cand_vote_recvd, total_votes, vote_accept, vote_reject,
           overflow, winner_idx, winner_valid, tie
  );

endinterface

// File: rtl/vote_max_scan.sv
// Sequential argmax over the packed tallies, one candidate per clock; lowest index wins ties.
// With VOTE_TIE_DETECT_EN defined it also reports whether another candidate equals the maximum.
module vote_max_scan import vote_pkg::*; #(
  parameter int NUM_CAND = DEF_NUM_CAND,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [NUM_CAND*CNT_W-1:0]     tallies,
  output logic                          done,
  output logic [idx_w(NUM_CAND)-1:0]    best_idx,
  output logic                          tie
);

  localparam int             IW   = idx_w(NUM_CAND);
  localparam logic [IW-1:0]  LAST = IW'(NUM_CAND - 1);

  logic [CNT_W-1:0] tv [NUM_CAND];
  logic [CNT_W-1:0] cur;
  logic [CNT_W-1:0] best_q, best_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    best_idx_q, best_idx_d;
  logic             active_q, active_d;
  logic             take;

  // best_idx/tie are the values including the candidate processed this cycle, valid with done.
  always_comb begin
    for (int i = 0; i < NUM_CAND; i++) tv[i] = tallies[i*CNT_W +: CNT_W];
    cur        = tv[idx_q];
    done       = active_q && (idx_q == LAST);
    take       = (idx_q == '0) || (cur > best_q);
    best_idx   = take ? idx_q : best_idx_q;
    active_d   = active_q;
    idx_d      = idx_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    if (abort) begin
      active_d = 1'b0;
    end else if (start) begin
      active_d   = 1'b1;
      idx_d      = '0;
      best_d     = '0;
      best_idx_d = '0;
    end else if (active_q) begin
      active_d   = !done;
      if (!done) idx_d = idx_q + 1'b1;
      if (take) best_d = cur;
      best_idx_d = best_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      active_q   <= 1'b0;
      idx_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
    end else begin
      active_q   <= active_d;
      idx_q      <= idx_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
    end
  end

`ifdef VOTE_TIE_DETECT_EN
  logic tie_q, tie_d;

  always_comb begin
    tie   = take ? 1'b0 : (tie_q | (cur == best_q));
    tie_d = tie_q;
    if (start) tie_d = 1'b0;
    else if (active_q) tie_d = tie;
  end

  always_ff @(posedge clock) begin
    if (reset) tie_q <= 1'b0;
    else       tie_q <= tie_d;
  end
`else
  assign tie = 1'b0;
`endif

endmodule

// File: rtl/vote_tally.sv
// Ballot counter: press edge detect, vote qualification, saturating tallies and poll FSM.
// Tie reporting is built only when VOTE_TIE_DETECT_EN is defined; otherwise tie stays 0.
//   state  | meaning
//   VOTE   | poll open, presses counted
//   SCAN   | poll closed, argmax walking the frozen tallies
//   RESULT | winner_idx/tie valid, winner_valid high
module vote_tally import vote_pkg::*; #(
  parameter int NUM_CAND = DEF_NUM_CAND,
  parameter int CNT_W    = DEF_CNT_W
) (
  input logic         clock,
  input logic         reset,
  vote_tally_if.slave bus
);

  localparam int               IW    = idx_w(NUM_CAND);
  localparam int               TOT_W = CNT_W + $clog2(NUM_CAND);
  localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};

  vote_state_e               state_q, state_d;
  logic [NUM_CAND-1:0]       prev_q;
  logic [CNT_W-1:0]          tally_q [NUM_CAND];
  logic [CNT_W-1:0]          tally_d [NUM_CAND];
  logic [NUM_CAND*CNT_W-1:0] tally_vec;
  logic [TOT_W-1:0]          total_q, total_d;
  logic                      accept_q, accept_d, reject_q, reject_d;
  logic                      ovf_q, ovf_d, wv_q, wv_d, tie_q, tie_d;
  logic [IW-1:0]             widx_q, widx_d, sel, scan_idx;
  logic                      press, scan_start, scan_abort, scan_done, scan_tie;

  assign press      = (prev_q == '0) && (bus.cand_valid_vote != '0);
  assign scan_start = (state_q == VOTE) && bus.mode;
  assign scan_abort = (state_q == SCAN) && !bus.mode;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (bus.cand_valid_vote[i]) sel = IW'(i);
      tally_vec[i*CNT_W +: CNT_W] = tally_q[i];
    end
  end

  vote_max_scan #(.NUM_CAND(NUM_CAND), .CNT_W(CNT_W)) u_scan (
    .clock    (clock),
    .reset    (reset),
    .start    (scan_start),
    .abort    (scan_abort),
    .tallies  (tally_vec),
    .done     (scan_done),
    .best_idx (scan_idx),
    .tie      (scan_tie)
  );

  always_comb begin
    state_d  = state_q;
    tally_d  = tally_q;
    total_d  = total_q;
    accept_d = 1'b0;
    reject_d = 1'b0;
    ovf_d    = ovf_q;
    wv_d     = wv_q;
    widx_d   = widx_q;
    tie_d    = tie_q;

    // A press on the closing edge sees mode==1 here, so it is refused and the scan reads frozen tallies.
    if (press) begin
      if ((state_q == VOTE) && !bus.mode && $onehot(bus.cand_valid_vote)) begin
        if (tally_q[sel] == C_MAX) begin
          reject_d = 1'b1;
          ovf_d    = 1'b1;
        end else begin
          tally_d[sel] = tally_q[sel] + 1'b1;
          total_d      = total_q + 1'b1;
          accept_d     = 1'b1;
        end
      end else begin
        reject_d = 1'b1;
      end
    end

    case (state_q)
      VOTE: if (bus.mode) state_d = SCAN;
      SCAN: begin
        if (!bus.mode) begin
          state_d = VOTE;
        end else if (scan_done) begin
          state_d = RESULT;
          wv_d    = 1'b1;
          widx_d  = scan_idx;
          tie_d   = scan_tie;
        end
      end
      RESULT: begin
        if (!bus.mode) begin
          state_d = VOTE;
          wv_d    = 1'b0;
          tie_d   = 1'b0;
        end
      end
      default: state_d = VOTE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= VOTE;
      prev_q   <= '0;
      for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= '0;
      total_q  <= '0;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
      ovf_q    <= 1'b0;
      wv_q     <= 1'b0;
      widx_q   <= '0;
      tie_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= bus.cand_valid_vote;
      tally_q  <= tally_d;
      total_q  <= total_d;
      accept_q <= accept_d;
      reject_q <= reject_d;
      ovf_q    <= ovf_d;
      wv_q     <= wv_d;
      widx_q   <= widx_d;
      tie_q    <= tie_d;
    end
  end

  assign bus.cand_vote_recvd = tally_vec;
  assign bus.total_votes     = total_q;
  assign bus.vote_accept     = accept_q;
  assign bus.vote_reject     = reject_q;
  assign bus.overflow        = ovf_q;
  assign bus.winner_idx      = widx_q;
  assign bus.winner_valid    = wv_q;
  assign bus.tie             = tie_q;

endmodule
